bb_transfer_ctrl: RTL and testbench

Sequencer that drives the one-hot unit enable buses (unit_ien/unit_oen) consumed by the core register file and the other bus units. It runs a fetch/decode/execute loop: fetch an instruction word from skin memory into IR, decode the source and destination unit indices, then issue one bus transfer. It handshakes with the skin memory interface and has a bounded wait timeout.

---
 rtl/bb_transfer_ctrl_pkg.sv | 47 ++++
 rtl/bb_transfer_ctrl_index_decode.sv | 22 ++
 rtl/bb_transfer_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_bb_transfer_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bb_transfer_ctrl_pkg.sv
// bb_transfer_ctrl_pkg
//   Shared definitions for the bus transfer sequencer: unit index map,
//   FSM state encoding, instruction-register field positions and the
//   fixed strobe patterns used by the fetch phase.
package bb_transfer_ctrl_pkg;

  localparam int UNIT_W = 16;  // width of the one-hot enable buses
  localparam int IDX_W  = 4;   // width of a unit index

  // Unit index map
  localparam logic [IDX_W-1:0] UNIT_NULL  = 4'd0;
  localparam logic [IDX_W-1:0] UNIT_IR    = 4'd1;
  localparam logic [IDX_W-1:0] UNIT_PC    = 4'd2;
  localparam logic [IDX_W-1:0] UNIT_AR    = 4'd3;
  localparam logic [IDX_W-1:0] UNIT_DR0   = 4'd4;
  localparam logic [IDX_W-1:0] UNIT_DR1   = 4'd5;
  localparam logic [IDX_W-1:0] UNIT_CR    = 4'd6;
  localparam logic [IDX_W-1:0] UNIT_SKIN0 = 4'd12;
  localparam logic [IDX_W-1:0] UNIT_SKIN1 = 4'd13;
  localparam logic [IDX_W-1:0] UNIT_SKIN2 = 4'd14;
  localparam logic [IDX_W-1:0] UNIT_HALT  = 4'd15;

  // Instruction register fields: [7:4] source, [3:0] destination
  localparam int IR_SRC_LSB = 4;
  localparam int IR_DST_LSB = 0;

  // Bit 0 (NULL) and bit 15 (HALT pseudo-unit) are never real bus units
  localparam logic [UNIT_W-1:0] STROBE_MASK = 16'h7FFE;

  // Instruction fetch moves SKIN0 onto the bus and loads IR
  localparam logic [UNIT_W-1:0] FETCH_OEN = 16'h1000;
  localparam logic [UNIT_W-1:0] FETCH_IEN = 16'h0002;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_SKIN_WAIT = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  // True for the three skin memory units (12..14)
  function automatic logic is_skin_unit(input logic [IDX_W-1:0] idx);
    return (idx >= UNIT_SKIN0) && (idx <= UNIT_SKIN2);
  endfunction

endpackage

// File: rtl/bb_transfer_ctrl_index_decode.sv
// bb_index_decode
//   Converts a 4-bit unit index into a 16-bit one-hot enable vector.
//   Index 0 is the NULL unit and produces an all-zero vector.
// Ports:
//   idx     in   4   unit index
//   onehot  out  16  one-hot enable (zero for index 0)
module bb_index_decode
  import bb_transfer_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [UNIT_W-1:0] onehot
);

  for (genvar gi = 0; gi < UNIT_W; gi++) begin : g_bit
    if (gi == 0) begin : g_null
      assign onehot[gi] = 1'b0;
    end else begin : g_unit
      assign onehot[gi] = (idx == IDX_W'(gi));
    end
  end

endmodule

// File: rtl/bb_transfer_ctrl.sv
// bb_transfer_ctrl
//   Fetch/decode/execute sequencer driving the one-hot unit enable buses.
//   FETCH reads an instruction word from SKIN0 into IR, DECODE splits it
//   into source/destination unit indices, and EXEC (register source) or
//   SKIN_WAIT (skin memory source) performs the single bus transfer.
//   Skin accesses are bounded by WAIT_MAX waiting cycles; on timeout the
//   sticky error flag is set and the sequencer parks in HALT.
// Ports:
//   clk            in   1           core clock
//   rst            in   1           asynchronous active-high reset
//   i_instruction  in   DATA_WIDTH  current IR contents ([7:4] src, [3:0] dst)
//   i_skin_ready   in   1           skin data valid this cycle
//   i_resume       in   1           leave HALT, clear error
//   o_unit_ien     out  16          one-hot load enable
//   o_unit_oen     out  16          one-hot output enable
//   o_skin_req     out  1           skin memory request
//   o_skin_sel     out  2           skin unit select (0..2 = unit 12..14)
//   o_halted       out  1           high in HALT
//   o_error        out  1           sticky skin timeout flag
//
// DATA_WIDTH must be at least 8; WAIT_MAX must be at least 1.
module bb_transfer_ctrl
  import bb_transfer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WAIT_MAX   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_instruction,
  input  logic                  i_skin_ready,
  input  logic                  i_resume,
  output logic [UNIT_W-1:0]     o_unit_ien,
  output logic [UNIT_W-1:0]     o_unit_oen,
  output logic                  o_skin_req,
  output logic [1:0]            o_skin_sel,
  output logic                  o_halted,
  output logic                  o_error
);

  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  // The WAIT_MAX-th waiting cycle is the one observed with this count
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    wait_cnt_reg, wait_cnt_next;
  logic                req_reg, req_next;
  logic [1:0]          sel_reg, sel_next;
  logic                halted_reg, halted_next;
  logic                error_reg, error_next;
  // Strobes for a register-to-register transfer (EXEC cycle)
  logic [UNIT_W-1:0]   oen_reg, oen_next;
  logic [UNIT_W-1:0]   ien_reg, ien_next;
  // Strobe pattern armed while waiting on skin memory; it reaches the bus
  // only in the cycle the memory reports ready, because skin data is only
  // valid in that cycle.
  logic [UNIT_W-1:0]   pend_oen_reg, pend_oen_next;
  logic [UNIT_W-1:0]   pend_ien_reg, pend_ien_next;

  logic [IDX_W-1:0]    src_idx;
  logic [IDX_W-1:0]    dst_idx;
  logic [UNIT_W-1:0]   src_onehot;
  logic [UNIT_W-1:0]   dst_onehot;
  logic                skin_hit;
  logic                wait_timeout;

  assign src_idx = i_instruction[IR_SRC_LSB +: IDX_W];
  assign dst_idx = i_instruction[IR_DST_LSB +: IDX_W];

  if (DATA_WIDTH > 8) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^i_instruction[DATA_WIDTH-1:8];
  end

  bb_index_decode u_src_decode (
    .idx    (src_idx),
    .onehot (src_onehot)
  );

  bb_index_decode u_dst_decode (
    .idx    (dst_idx),
    .onehot (dst_onehot)
  );

  // Ready only counts while a request is actually outstanding
  assign skin_hit     = req_reg & i_skin_ready;
  assign wait_timeout = req_reg & ~i_skin_ready & (wait_cnt_reg == CNT_LAST);

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    req_next      = 1'b0;
    sel_next      = 2'd0;
    halted_next   = 1'b0;
    error_next    = error_reg;
    oen_next      = '0;
    ien_next      = '0;
    pend_oen_next = '0;
    pend_ien_next = '0;

    case (state_reg)
      ST_FETCH: begin
        if (skin_hit) begin
          state_next = ST_DECODE;
        end else if (!req_reg) begin
          // First cycle out of reset: raise the instruction fetch request
          req_next      = 1'b1;
          pend_oen_next = FETCH_OEN;
          pend_ien_next = FETCH_IEN;
        end else if (wait_timeout) begin
          state_next  = ST_HALT;
          halted_next = 1'b1;
          error_next  = 1'b1;
        end else begin
          req_next      = 1'b1;
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
          pend_oen_next = pend_oen_reg;
          pend_ien_next = pend_ien_reg;
        end
      end

      ST_DECODE: begin
        if (src_idx == UNIT_HALT) begin
          state_next  = ST_HALT;
          halted_next = 1'b1;
        end else if (is_skin_unit(src_idx)) begin
          state_next    = ST_SKIN_WAIT;
          req_next      = 1'b1;
          // Units 12/13/14 have low bits 00/01/10, which is the select code
          sel_next      = src_idx[1:0];
          pend_oen_next = src_onehot & STROBE_MASK;
          pend_ien_next = dst_onehot & STROBE_MASK;
        end else begin
          state_next = ST_EXEC;
          oen_next   = src_onehot & STROBE_MASK;
          ien_next   = dst_onehot & STROBE_MASK;
        end
      end

      ST_EXEC: begin
        state_next    = ST_FETCH;
        req_next      = 1'b1;
        pend_oen_next = FETCH_OEN;
        pend_ien_next = FETCH_IEN;
      end

      ST_SKIN_WAIT: begin
        if (skin_hit) begin
          state_next    = ST_FETCH;
          req_next      = 1'b1;
          pend_oen_next = FETCH_OEN;
          pend_ien_next = FETCH_IEN;
        end else if (wait_timeout) begin
          state_next  = ST_HALT;
          halted_next = 1'b1;
          error_next  = 1'b1;
        end else begin
          req_next      = 1'b1;
          sel_next      = sel_reg;
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
          pend_oen_next = pend_oen_reg;
          pend_ien_next = pend_ien_reg;
        end
      end

      ST_HALT: begin
        halted_next = 1'b1;
        if (i_resume) begin
          state_next    = ST_FETCH;
          halted_next   = 1'b0;
          error_next    = 1'b0;
          req_next      = 1'b1;
          pend_oen_next = FETCH_OEN;
          pend_ien_next = FETCH_IEN;
        end
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_FETCH;
      wait_cnt_reg <= '0;
      req_reg      <= 1'b0;
      sel_reg      <= 2'd0;
      halted_reg   <= 1'b0;
      error_reg    <= 1'b0;
      oen_reg      <= '0;
      ien_reg      <= '0;
      pend_oen_reg <= '0;
      pend_ien_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      req_reg      <= req_next;
      sel_reg      <= sel_next;
      halted_reg   <= halted_next;
      error_reg    <= error_next;
      oen_reg      <= oen_next;
      ien_reg      <= ien_next;
      pend_oen_reg <= pend_oen_next;
      pend_ien_reg <= pend_ien_next;
    end
  end

  // The EXEC pattern and the armed skin pattern are never both non-zero
  // in the same state, so the OR stays one-hot.
  assign o_unit_oen = oen_reg | (pend_oen_reg & {UNIT_W{skin_hit}});
  assign o_unit_ien = ien_reg | (pend_ien_reg & {UNIT_W{skin_hit}});
  assign o_skin_req = req_reg;
  assign o_skin_sel = sel_reg;
  assign o_halted   = halted_reg;
  assign o_error    = error_reg;

endmodule

// File: tb/tb_bb_transfer_ctrl.sv
module tb_bb_transfer_ctrl;

  typedef struct packed {
    logic [15:0] oen;
    logic [15:0] ien;
    logic        req;
    logic [1:0]  sel;
    logic        halted;
    logic        error;
  } obs_t;

  logic        clk = 1'b0;
  // Instance A: default WAIT_MAX
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0045;
  logic        ready = 1'b1;
  logic        resume = 1'b0;
  logic [15:0] ien_a, oen_a;
  logic        req_a, halted_a, error_a;
  logic [1:0]  sel_a;
  // Instance B: WAIT_MAX = 4 for the timeout tests
  logic        rst_b = 1'b1;
  logic [15:0] instr_b = 16'h0045;
  logic        ready_b = 1'b0;
  logic        resume_b = 1'b0;
  logic [15:0] ien_b, oen_b;
  logic        req_b, halted_b, error_b;
  logic [1:0]  sel_b;

  int checks = 0;
  int failures = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  bb_transfer_ctrl #(.DATA_WIDTH(16), .WAIT_MAX(64)) dut (
    .clk(clk), .rst(rst), .i_instruction(instr), .i_skin_ready(ready),
    .i_resume(resume), .o_unit_ien(ien_a), .o_unit_oen(oen_a),
    .o_skin_req(req_a), .o_skin_sel(sel_a), .o_halted(halted_a), .o_error(error_a)
  );

  bb_transfer_ctrl #(.DATA_WIDTH(16), .WAIT_MAX(4)) dut_b (
    .clk(clk), .rst(rst_b), .i_instruction(instr_b), .i_skin_ready(ready_b),
    .i_resume(resume_b), .o_unit_ien(ien_b), .o_unit_oen(oen_b),
    .o_skin_req(req_b), .o_skin_sel(sel_b), .o_halted(halted_b), .o_error(error_b)
  );

  // Push the expectation for the current cycle, then pop and compare it at
  // the falling edge, then advance to just after the next rising edge.
  task automatic chk(input int which, input string tag, input logic [15:0] e_oen,
                     input logic [15:0] e_ien, input logic e_req, input logic [1:0] e_sel,
                     input logic e_halt, input logic e_err);
    obs_t e, o;
    string t;
    exp_q.push_back({e_oen, e_ien, e_req, e_sel, e_halt, e_err});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (which == 0) o = {oen_a, ien_a, req_a, sel_a, halted_a, error_a};
    else            o = {oen_b, ien_b, req_b, sel_b, halted_b, error_b};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed oen=%h ien=%h req=%b sel=%0d halt=%b err=%b expected oen=%h ien=%h req=%b sel=%0d halt=%b err=%b",
             t, o.oen, o.ien, o.req, o.sel, o.halted, o.error,
             e.oen, e.ien, e.req, e.sel, e.halted, e.error);
    end
    $display("cycle %s: oen=%h ien=%h req=%b sel=%0d halt=%b err=%b",
             t, o.oen, o.ien, o.req, o.sel, o.halted, o.error);
    @(posedge clk);
    #1;
  endtask

  // Register-source instruction starting from a FETCH with request up
  task automatic run_reg(input string tag, input logic [15:0] ir,
                         input logic [15:0] e_oen, input logic [15:0] e_ien);
    instr = ir;
    ready = 1'b1;
    chk(0, {tag, "_fetch"}, 16'h1000, 16'h0002, 1'b1, 2'd0, 1'b0, 1'b0);
    chk(0, {tag, "_decode"}, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
    chk(0, {tag, "_exec"}, e_oen, e_ien, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // Skin-source instruction with a given number of not-ready cycles
  task automatic run_skin(input string tag, input logic [15:0] ir, input int waits,
                          input logic [1:0] e_sel, input logic [15:0] e_oen,
                          input logic [15:0] e_ien);
    instr = ir;
    ready = 1'b1;
    chk(0, {tag, "_fetch"}, 16'h1000, 16'h0002, 1'b1, 2'd0, 1'b0, 1'b0);
    ready = 1'b0;
    chk(0, {tag, "_decode"}, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < waits; i++)
      chk(0, {tag, "_wait"}, 16'h0000, 16'h0000, 1'b1, e_sel, 1'b0, 1'b0);
    ready = 1'b1;
    chk(0, {tag, "_xfer"}, e_oen, e_ien, 1'b1, e_sel, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // Reset held with ready high: everything quiet
    chk(0, "reset_held", 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    chk(0, "post_reset", 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);

    // 3-cycle period for register instructions
    for (int i = 0; i < 3; i++) run_reg("ir45", 16'h0045, 16'h0010, 16'h0020);
    run_reg("ir44", 16'h0044, 16'h0010, 16'h0010);
    run_reg("ir05", 16'h0005, 16'h0000, 16'h0020);
    run_reg("ir50", 16'h0050, 16'h0020, 16'h0000);
    run_reg("nop", 16'h0000, 16'h0000, 16'h0000);
    run_reg("dst15", 16'h004F, 16'h0010, 16'h0000);
    run_reg("hibits", 16'hAB36, 16'h0008, 16'h0040);

    // Skin sources
    run_skin("irD3", 16'h00D3, 5, 2'd1, 16'h2000, 16'h0008);
    run_skin("irC4", 16'h00C4, 0, 2'd0, 16'h1000, 16'h0010);
    run_skin("irE6", 16'h00E6, 2, 2'd2, 16'h4000, 16'h0040);

    // Resume outside HALT is ignored
    resume = 1'b1;
    run_reg("resume_ign", 16'h0045, 16'h0010, 16'h0020);
    resume = 1'b0;

    // HALT instruction
    instr = 16'h00F0;
    ready = 1'b1;
    chk(0, "halt_fetch", 16'h1000, 16'h0002, 1'b1, 2'd0, 1'b0, 1'b0);
    chk(0, "halt_decode", 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk(0, "halt_1", 16'h0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk(0, "halt_2", 16'h0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    resume = 1'b1;
    chk(0, "halt_resume", 16'h0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    resume = 1'b0;
    run_reg("after_halt", 16'h0045, 16'h0010, 16'h0020);

    // Reset asserted in the middle of a skin wait
    instr = 16'h00D3;
    ready = 1'b1;
    chk(0, "rw_fetch", 16'h1000, 16'h0002, 1'b1, 2'd0, 1'b0, 1'b0);
    ready = 1'b0;
    chk(0, "rw_decode", 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk(0, "rw_wait", 16'h0, 16'h0, 1'b1, 2'd1, 1'b0, 1'b0);
    rst = 1'b1;
    ready = 1'b1;
    chk(0, "rw_reset", 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    ready = 1'b0;
    chk(0, "rw_post", 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk(0, "rw_fetch_req", 16'h0, 16'h0, 1'b1, 2'd0, 1'b0, 1'b0);
    ready = 1'b1;
    chk(0, "rw_fetch_go", 16'h1000, 16'h0002, 1'b1, 2'd0, 1'b0, 1'b0);

    // Timeout with WAIT_MAX = 4
    chk(1, "b_reset_held", 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst_b = 1'b0;
    ready_b = 1'b0;
    chk(1, "b_post_reset", 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      chk(1, "b_wait", 16'h0, 16'h0, 1'b1, 2'd0, 1'b0, 1'b0);
    chk(1, "b_timeout", 16'h0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b1);
    chk(1, "b_halt_hold", 16'h0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b1);
    resume_b = 1'b1;
    chk(1, "b_resume", 16'h0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b1);
    resume_b = 1'b0;
    // Ready on the 4th waiting cycle wins over the timeout
    for (int i = 0; i < 3; i++)
      chk(1, "b_rewait", 16'h0, 16'h0, 1'b1, 2'd0, 1'b0, 1'b0);
    ready_b = 1'b1;
    chk(1, "b_ready_wins", 16'h1000, 16'h0002, 1'b1, 2'd0, 1'b0, 1'b0);
    chk(1, "b_decode", 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
